// File: rtl/mux_lut_cam.sv
// mux_lut_cam: run-time writable key/value table with registered lookup
module mux_lut_cam #(
    parameter int KEY_LEN = 4,
    parameter int DATA_LEN = 8,
    parameter int ITEM_NUM = 8,
    parameter int HAS_DEFAULT = 1,
    localparam int IDX_W = $clog2(ITEM_NUM),
    localparam int CNT_W = $clog2(ITEM_NUM + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                del_en,
    input  logic [KEY_LEN-1:0]  del_key,
    output logic                wr_err,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    input  logic [DATA_LEN-1:0] default_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic                rsp_hit,
    output logic [IDX_W-1:0]    rsp_idx
);
    logic [KEY_LEN-1:0]  key_q [ITEM_NUM];
    logic [DATA_LEN-1:0] data_q [ITEM_NUM];
    logic [ITEM_NUM-1:0] vld_q;
    logic                wr_hit, free_ok, del_hit, lk_hit, accept;
    logic [IDX_W-1:0]    wr_idx, free_idx, del_idx, lk_idx;
    logic [CNT_W-1:0]    cnt;
    always_comb begin
        wr_hit = 1'b0;
        wr_idx = '0;
        free_ok = 1'b0;
        free_idx = '0;
        del_hit = 1'b0;
        del_idx = '0;
        lk_hit = 1'b0;
        lk_idx = '0;
        cnt = '0;
        for (int i = ITEM_NUM - 1; i >= 0; i--) begin
            if (vld_q[i] && key_q[i] == wr_key) begin
                wr_hit = 1'b1;
                wr_idx = IDX_W'(i);
            end
            if (!vld_q[i]) begin
                free_ok = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (vld_q[i] && key_q[i] == del_key) begin
                del_hit = 1'b1;
                del_idx = IDX_W'(i);
            end
            if (vld_q[i] && key_q[i] == req_key) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            cnt = cnt + CNT_W'(vld_q[i]);
        end
    end
    assign count = cnt;
    assign full = cnt == CNT_W'(ITEM_NUM);
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept = req_valid && req_ready;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            wr_err <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_hit <= 1'b0;
            rsp_idx <= '0;
        end else begin
            wr_err <= wr_en && !wr_hit && !free_ok;
            if (wr_en) begin
                if (wr_hit) begin
                    data_q[wr_idx] <= wr_data;
                end else if (free_ok) begin
                    key_q[free_idx] <= wr_key;
                    data_q[free_idx] <= wr_data;
                    vld_q[free_idx] <= 1'b1;
                end
            end else if (del_en && del_hit) begin
                vld_q[del_idx] <= 1'b0;
            end
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_data <= lk_hit ? data_q[lk_idx] : (HAS_DEFAULT != 0 ? default_out : '0);
                rsp_hit <= lk_hit;
                rsp_idx <= lk_idx;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_lut_cam.sv
// tb_mux_lut_cam: directed and random checks of mux_lut_cam against a table model
module tb_mux_lut_cam;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0, del_en = 1'b0, req_valid = 1'b0, rsp_ready = 1'b1;
    logic [3:0] wr_key = '0, del_key = '0, req_key = '0;
    logic [7:0] wr_data = '0, default_out = '0;
    logic       wr_err, full, req_ready, rsp_valid, rsp_hit;
    logic [3:0] count;
    logic [7:0] rsp_data;
    logic [2:0] rsp_idx;
    logic       wr_err2, full2, req_ready2, rsp_valid2, rsp_hit2;
    logic [3:0] count2;
    logic [7:0] rsp_data2;
    logic [2:0] rsp_idx2;
    logic [3:0] m_key [8];
    logic [7:0] m_data [8];
    bit         m_vld [8];
    bit         m_rv, m_hit, m_err;
    int         m_idx;
    logic [7:0] m_rd, m_rd0;
    int         n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    mux_lut_cam #(.HAS_DEFAULT(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data),
        .del_en(del_en), .del_key(del_key), .wr_err(wr_err), .count(count), .full(full),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .default_out(default_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
        .rsp_idx(rsp_idx)
    );

    mux_lut_cam #(.HAS_DEFAULT(0)) dut_nd (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data),
        .del_en(del_en), .del_key(del_key), .wr_err(wr_err2), .count(count2), .full(full2),
        .req_valid(req_valid), .req_ready(req_ready2), .req_key(req_key), .default_out(default_out),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_hit(rsp_hit2),
        .rsp_idx(rsp_idx2)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find(logic [3:0] k);
        for (int i = 0; i < 8; i++)
            if (m_vld[i] && m_key[i] == k) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m_vld[i]);
        return c;
    endfunction

    task automatic tick();
        int  li, wi, fi, di;
        bit  rdy;
        #1;
        rdy = !m_rv || rsp_ready;
        check("req_ready", req_ready, rdy);
        check("req_ready_nd", req_ready2, rdy);
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_vld[i] = 0;
            m_rv = 0; m_hit = 0; m_idx = 0; m_rd = 0; m_rd0 = 0; m_err = 0;
        end else begin
            if (req_valid && rdy) begin
                li = find(req_key);
                m_rv = 1;
                m_hit = li >= 0;
                m_idx = li >= 0 ? li : 0;
                m_rd = li >= 0 ? m_data[li] : default_out;
                m_rd0 = li >= 0 ? m_data[li] : 8'h00;
            end else if (rsp_ready) begin
                m_rv = 0;
            end
            m_err = 0;
            if (wr_en) begin
                wi = find(wr_key);
                fi = -1;
                for (int i = 7; i >= 0; i--) if (!m_vld[i]) fi = i;
                if (wi >= 0) m_data[wi] = wr_data;
                else if (fi >= 0) begin
                    m_key[fi] = wr_key; m_data[fi] = wr_data; m_vld[fi] = 1;
                end else m_err = 1;
            end else if (del_en) begin
                di = find(del_key);
                if (di >= 0) m_vld[di] = 0;
            end
        end
        #1;
        check("rsp_valid", rsp_valid, m_rv);
        check("rsp_data", rsp_data, m_rd);
        check("rsp_hit", rsp_hit, m_hit);
        check("rsp_idx", rsp_idx, m_idx);
        check("count", count, m_count());
        check("full", full, m_count() == 8);
        check("wr_err", wr_err, m_err);
        check("rsp_valid_nd", rsp_valid2, m_rv);
        check("rsp_data_nd", rsp_data2, m_rd0);
        check("rsp_hit_nd", rsp_hit2, m_hit);
        check("rsp_idx_nd", rsp_idx2, m_idx);
        check("count_nd", count2, m_count());
        check("full_nd", full2, m_count() == 8);
        check("wr_err_nd", wr_err2, m_err);
    endtask

    task automatic ins(logic [3:0] k, logic [7:0] d);
        wr_en = 1; wr_key = k; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic look(logic [3:0] k);
        req_valid = 1; req_key = k;
        tick();
        req_valid = 0;
    endtask

    initial begin
        rst_n = 0;
        tick();
        tick();
        check("rst_valid", rsp_valid, 0);
        check("rst_count", count, 0);
        rst_n = 1;
        ins(1, 8'h11); ins(2, 8'h22); ins(3, 8'h33);
        look(2);
        check("lk2_valid", rsp_valid, 1);
        check("lk2_data", rsp_data, 8'h22);
        check("lk2_idx", rsp_idx, 1);
        check("lk2_count", count, 3);
        default_out = 8'hAA;
        look(5);
        check("miss_def", rsp_data, 8'hAA);
        check("miss_nodef", rsp_data2, 8'h00);
        check("miss_hit", rsp_hit, 0);
        req_valid = 1; req_key = 2;
        ins(2, 8'h99);
        req_valid = 0;
        check("rbw_data", rsp_data, 8'h22);
        look(2);
        check("upd_data", rsp_data, 8'h99);
        check("upd_count", count, 3);
        del_en = 1; del_key = 1; tick(); del_en = 0;
        check("del_count", count, 2);
        ins(7, 8'h77);
        look(7);
        check("reuse_idx", rsp_idx, 0);
        del_en = 1; del_key = 9; tick(); del_en = 0;
        check("del_absent", count, 3);
        for (int k = 8; k <= 12; k++) ins(4'(k), 8'(k * 3));
        check("fill_full", full, 1);
        ins(4'hF, 8'hFF);
        check("drop_err", wr_err, 1);
        check("drop_count", count, 8);
        tick();
        check("err_pulse", wr_err, 0);
        del_en = 1; del_key = 3;
        ins(2, 8'h44);
        del_en = 0;
        look(3);
        check("both_del_drop", rsp_idx, 2);
        look(2);
        check("both_ins", rsp_data, 8'h44);
        rsp_ready = 0; req_valid = 1; req_key = 7;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_rdy", req_ready, 0);
            check("stall_data", rsp_data, 8'h44);
        end
        rsp_ready = 1;
        tick(); check("b2b_0", rsp_data, 8'h77);
        req_key = 2; tick(); check("b2b_1", rsp_idx, 1);
        req_key = 3; tick(); check("b2b_2", rsp_data, 8'h33);
        rst_n = 0; tick();
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_count", count, 0);
        rst_n = 1; req_valid = 0;
        for (int c = 0; c < 600; c++) begin
            rst_n = $urandom_range(149) != 0;
            wr_en = $urandom_range(2) == 0;
            del_en = $urandom_range(3) == 0;
            wr_key = 4'($urandom); del_key = 4'($urandom); req_key = 4'($urandom);
            wr_data = 8'($urandom); default_out = 8'($urandom);
            req_valid = $urandom_range(9) < 7;
            rsp_ready = $urandom_range(9) < 6;
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
